// File: rtl/match_round_controller.sv
// Round/match flow controller for the fighting game.
// Watches both players' health, sequences countdown -> fight -> result,
// keeps best-of-N win tallies, and gates the physics/health stages and
// player input between rounds. Every output is a register.
module match_round_controller #(
  parameter int TICKS_PER_SEC     = 20,
  parameter int ROUND_SECONDS     = 99,
  parameter int COUNTDOWN_SECONDS = 3,
  parameter int RESULT_SECONDS    = 2,
  parameter int ROUNDS_TO_WIN     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic [8:0] health_1,
  input  logic [8:0] health_2,
  output logic [2:0] state,
  output logic       round_reset,
  output logic       fight_enable,
  output logic [1:0] countdown,
  output logic [6:0] timer_s,
  output logic [1:0] round_winner,
  output logic [1:0] wins_1,
  output logic [1:0] wins_2,
  output logic [1:0] match_winner
);

  localparam int SUB_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [SUB_W-1:0] SUB_MAX  = SUB_W'(TICKS_PER_SEC - 1);
  localparam logic [SUB_W-1:0] SUB_ZERO = SUB_W'(0);
  localparam logic [SUB_W-1:0] SUB_ONE  = SUB_W'(1);
  localparam logic [6:0] ROUND_S = 7'(ROUND_SECONDS);
  localparam logic [6:0] CD_S    = 7'(COUNTDOWN_SECONDS);
  localparam logic [6:0] RES_S   = 7'(RESULT_SECONDS);
  localparam logic [1:0] WIN_N   = 2'(ROUNDS_TO_WIN);

  // Result / winner codes
  localparam logic [1:0] RES_NONE = 2'd0;
  localparam logic [1:0] RES_P1   = 2'd1;
  localparam logic [1:0] RES_P2   = 2'd2;
  localparam logic [1:0] RES_DRAW = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_FIGHT     = 3'd2,
    ST_ROUND_END = 3'd3,
    ST_MATCH_END = 3'd4
  } state_t;

  state_t           state_r, state_nx;
  logic             start_q_r;
  logic [SUB_W-1:0] sub_cnt_r, sub_nx;
  logic [6:0]       sec_cnt_r, sec_nx;
  logic [6:0]       timer_nx;
  logic [1:0]       rw_nx, w1_nx, w2_nx, mw_nx, cd_nx;
  logic [1:0]       result_s;
  logic             start_edge_s, sub_wrap_s;

  assign start_edge_s = start & ~start_q_r;
  assign sub_wrap_s   = tick & (sub_cnt_r == SUB_MAX);
  assign state        = state_r;

  // Round outcome as seen on the current tick, in priority order (KO before timeout)
  always_comb begin
    result_s = RES_NONE;
    if ((health_1 == 9'd0) && (health_2 == 9'd0)) begin
      result_s = RES_DRAW;
    end else if (health_1 == 9'd0) begin
      result_s = RES_P2;
    end else if (health_2 == 9'd0) begin
      result_s = RES_P1;
    end else if (timer_s == 7'd0) begin
      if (health_1 > health_2) begin
        result_s = RES_P1;
      end else if (health_2 > health_1) begin
        result_s = RES_P2;
      end else begin
        result_s = RES_DRAW;
      end
    end else begin
      result_s = RES_NONE;
    end
  end

  // Next-state, counter and scoreboard logic
  always_comb begin
    state_nx = state_r;
    sub_nx   = tick ? (sub_wrap_s ? SUB_ZERO : sub_cnt_r + SUB_ONE) : sub_cnt_r;
    sec_nx   = sec_cnt_r;
    timer_nx = timer_s;
    rw_nx    = round_winner;
    w1_nx    = wins_1;
    w2_nx    = wins_2;
    mw_nx    = match_winner;
    case (state_r)
      ST_IDLE: begin
        if (start_edge_s) begin
          state_nx = ST_COUNTDOWN;
          sub_nx   = SUB_ZERO;
          sec_nx   = CD_S;
          timer_nx = ROUND_S;
          rw_nx    = RES_NONE;
          w1_nx    = 2'd0;
          w2_nx    = 2'd0;
          mw_nx    = RES_NONE;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_COUNTDOWN: begin
        if (sub_wrap_s) begin
          if (sec_cnt_r == 7'd1) begin
            state_nx = ST_FIGHT;
            sub_nx   = SUB_ZERO;
            sec_nx   = 7'd0;
          end else begin
            sec_nx = sec_cnt_r - 7'd1;
          end
        end else begin
          sec_nx = sec_cnt_r;
        end
      end
      ST_FIGHT: begin
        if (tick) begin
          if (result_s != RES_NONE) begin
            state_nx = ST_ROUND_END;
            sub_nx   = SUB_ZERO;
            sec_nx   = RES_S;
            rw_nx    = result_s;
            if ((result_s == RES_P1) && (wins_1 != 2'd3)) begin
              w1_nx = wins_1 + 2'd1;
            end else if ((result_s == RES_P2) && (wins_2 != 2'd3)) begin
              w2_nx = wins_2 + 2'd1;
            end else begin
              w1_nx = wins_1;
            end
          end else if (sub_wrap_s && (timer_s != 7'd0)) begin
            timer_nx = timer_s - 7'd1;
          end else begin
            timer_nx = timer_s;
          end
        end else begin
          state_nx = ST_FIGHT;
        end
      end
      ST_ROUND_END: begin
        if (sub_wrap_s) begin
          if (sec_cnt_r == 7'd1) begin
            sub_nx = SUB_ZERO;
            if (wins_1 == WIN_N) begin
              state_nx = ST_MATCH_END;
              sec_nx   = 7'd0;
              mw_nx    = RES_P1;
            end else if (wins_2 == WIN_N) begin
              state_nx = ST_MATCH_END;
              sec_nx   = 7'd0;
              mw_nx    = RES_P2;
            end else begin
              state_nx = ST_COUNTDOWN;
              sec_nx   = CD_S;
              timer_nx = ROUND_S;
            end
          end else begin
            sec_nx = sec_cnt_r - 7'd1;
          end
        end else begin
          sec_nx = sec_cnt_r;
        end
      end
      ST_MATCH_END: begin
        if (start_edge_s) begin
          state_nx = ST_IDLE;
          sub_nx   = SUB_ZERO;
          sec_nx   = 7'd0;
        end else begin
          state_nx = ST_MATCH_END;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
    cd_nx = (state_nx == ST_COUNTDOWN) ? sec_nx[1:0] : 2'd0;
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      start_q_r    <= 1'b1;
      sub_cnt_r    <= SUB_ZERO;
      sec_cnt_r    <= 7'd0;
      round_reset  <= 1'b1;
      fight_enable <= 1'b0;
      countdown    <= 2'd0;
      timer_s      <= ROUND_S;
      round_winner <= RES_NONE;
      wins_1       <= 2'd0;
      wins_2       <= 2'd0;
      match_winner <= RES_NONE;
    end else begin
      state_r      <= state_nx;
      start_q_r    <= start;
      sub_cnt_r    <= sub_nx;
      sec_cnt_r    <= sec_nx;
      round_reset  <= (state_nx == ST_IDLE) || (state_nx == ST_COUNTDOWN);
      fight_enable <= (state_nx == ST_FIGHT);
      countdown    <= cd_nx;
      timer_s      <= timer_nx;
      round_winner <= rw_nx;
      wins_1       <= w1_nx;
      wins_2       <= w2_nx;
      match_winner <= mw_nx;
    end
  end

endmodule

// File: tb/tb_match_round_controller.sv
// Bench for match_round_controller: scripted match scenarios followed by a
// randomized phase, all compared every cycle against a tick-counting model.
module tb_match_round_controller;

  localparam int TPS = 20;
  localparam int RS  = 99;
  localparam int CDS = 3;
  localparam int RES = 2;
  localparam int RTW = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic [8:0] health_1 = 9'd100;
  logic [8:0] health_2 = 9'd100;
  logic [2:0] state;
  logic       round_reset, fight_enable;
  logic [1:0] countdown;
  logic [6:0] timer_s;
  logic [1:0] round_winner, wins_1, wins_2, match_winner;

  match_round_controller #(
    .TICKS_PER_SEC(TPS), .ROUND_SECONDS(RS), .COUNTDOWN_SECONDS(CDS),
    .RESULT_SECONDS(RES), .ROUNDS_TO_WIN(RTW)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start),
    .health_1(health_1), .health_2(health_2), .state(state),
    .round_reset(round_reset), .fight_enable(fight_enable),
    .countdown(countdown), .timer_s(timer_s), .round_winner(round_winner),
    .wins_1(wins_1), .wins_2(wins_2), .match_winner(match_winner)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model: phase 0..4 and ticks elapsed within the phase
  int m_state = 0, m_ticks = 0, m_timer = RS;
  int m_rw = 0, m_w1 = 0, m_w2 = 0, m_mw = 0;
  bit m_start_prev = 1'b1;

  // Stimulus controls
  int h1_set = 100, h2_set = 100;
  bit btn = 1'b0, rst_v = 1'b1;

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int round_result(input int h1, input int h2, input int tmr);
    if (h1 == 0 && h2 == 0) return 3;
    if (h1 == 0) return 2;
    if (h2 == 0) return 1;
    if (tmr == 0) return (h1 > h2) ? 1 : ((h2 > h1) ? 2 : 3);
    return 0;
  endfunction

  task automatic model_step();
    bit edge_v;
    int r;
    if (rst_v) begin
      m_state = 0; m_ticks = 0; m_timer = RS;
      m_rw = 0; m_w1 = 0; m_w2 = 0; m_mw = 0;
    end else begin
      edge_v = btn && !m_start_prev;
      case (m_state)
        0: if (edge_v) begin
             m_state = 1; m_ticks = 0; m_timer = RS;
             m_rw = 0; m_w1 = 0; m_w2 = 0; m_mw = 0;
           end
        1: if (tick) begin
             m_ticks++;
             if (m_ticks == CDS * TPS) begin m_state = 2; m_ticks = 0; end
           end
        2: if (tick) begin
             r = round_result(int'(health_1), int'(health_2), m_timer);
             if (r != 0) begin
               m_rw = r;
               if (r == 1 && m_w1 < 3) m_w1++;
               if (r == 2 && m_w2 < 3) m_w2++;
               m_state = 3; m_ticks = 0;
             end else begin
               m_ticks++;
               m_timer = RS - m_ticks / TPS;
               if (m_timer < 0) m_timer = 0;
             end
           end
        3: if (tick) begin
             m_ticks++;
             if (m_ticks == RES * TPS) begin
               m_ticks = 0;
               if (m_w1 == RTW) begin m_state = 4; m_mw = 1; end
               else if (m_w2 == RTW) begin m_state = 4; m_mw = 2; end
               else begin m_state = 1; m_timer = RS; end
             end
           end
        4: if (edge_v) m_state = 0;
        default: m_state = 0;
      endcase
    end
    m_start_prev = rst_v ? 1'b1 : btn;
  endtask

  // One clk: drive inputs, advance model, compare after the edge
  task automatic cycle(input bit t);
    reset = rst_v;
    start = btn;
    tick  = t;
    if (t) begin
      health_1 = 9'(h1_set);
      health_2 = 9'(h2_set);
    end else begin
      health_1 = ($urandom_range(0, 3) == 0) ? 9'd0 : 9'($urandom_range(1, 511));
      health_2 = ($urandom_range(0, 3) == 0) ? 9'd0 : 9'($urandom_range(1, 511));
    end
    model_step();
    @(posedge clk);
    #1;
    check_val("state", int'(state), m_state);
    check_val("round_reset", int'(round_reset), (m_state <= 1) ? 1 : 0);
    check_val("fight_enable", int'(fight_enable), (m_state == 2) ? 1 : 0);
    check_val("countdown", int'(countdown), (m_state == 1) ? (CDS - m_ticks / TPS) : 0);
    check_val("timer_s", int'(timer_s), m_timer);
    check_val("round_winner", int'(round_winner), m_rw);
    check_val("wins_1", int'(wins_1), m_w1);
    check_val("wins_2", int'(wins_2), m_w2);
    check_val("match_winner", int'(match_winner), m_mw);
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) cycle(1'b0);
      cycle(1'b1);
    end
  endtask

  initial begin
    // Reset with the button held: no edge afterwards
    rst_v = 1'b1; btn = 1'b1;
    repeat (3) cycle(1'b0);
    rst_v = 1'b0;
    run_ticks(5);
    check_val("held_idle", int'(state), 0);
    check_val("held_rr", int'(round_reset), 1);
    // Press with a simultaneous tick: start wins
    btn = 1'b0; cycle(1'b0);
    btn = 1'b1; cycle(1'b1);
    check_val("cd_entry", int'(state), 1);
    check_val("cd_first", int'(countdown), 3);
    btn = 1'b0; cycle(1'b0);
    h1_set = 200; h2_set = 300;
    run_ticks(60);
    check_val("fight_state", int'(state), 2);
    check_val("fight_en", int'(fight_enable), 1);
    check_val("fight_rr", int'(round_reset), 0);
    check_val("fight_timer", int'(timer_s), 99);
    run_ticks(30);
    btn = 1'b1; cycle(1'b0);
    check_val("start_ignored", int'(state), 2);
    btn = 1'b0; cycle(1'b0);
    // KO by P1
    h1_set = 50; h2_set = 0;
    run_ticks(1);
    check_val("ko_state", int'(state), 3);
    check_val("ko_winner", int'(round_winner), 1);
    check_val("ko_wins1", int'(wins_1), 1);
    h2_set = 300;
    run_ticks(39);
    check_val("hold_39", int'(state), 3);
    run_ticks(1);
    check_val("back_cd", int'(state), 1);
    run_ticks(70);
    h2_set = 0;
    run_ticks(1);
    h2_set = 300;
    run_ticks(40);
    check_val("match_state", int'(state), 4);
    check_val("match_win", int'(match_winner), 1);
    btn = 1'b1; cycle(1'b0);
    check_val("me_to_idle", int'(state), 0);
    btn = 1'b0; cycle(1'b0);
    btn = 1'b1; cycle(1'b0);
    check_val("wins_cleared", int'(wins_1), 0);
    btn = 1'b0;
    // Timeout with equal health: draw
    h1_set = 120; h2_set = 120;
    run_ticks(60 + 1980);
    check_val("to_timer0", int'(timer_s), 0);
    check_val("to_still_fight", int'(state), 2);
    run_ticks(1);
    check_val("to_draw", int'(round_winner), 3);
    check_val("to_w1", int'(wins_1), 0);
    check_val("to_w2", int'(wins_2), 0);
    // Timeout with P1 ahead by one
    run_ticks(100);
    h1_set = 121;
    run_ticks(1981);
    check_val("to_p1", int'(round_winner), 1);
    check_val("to_p1_wins", int'(wins_1), 1);
    // Double KO: draw, no increment
    run_ticks(100);
    h1_set = 0; h2_set = 0;
    run_ticks(1);
    check_val("dko_draw", int'(round_winner), 3);
    check_val("dko_w1", int'(wins_1), 1);
    h1_set = 200; h2_set = 200;
    run_ticks(100);
    h1_set = 0;
    run_ticks(1);
    check_val("p2_win", int'(wins_2), 1);
    h1_set = 200;
    run_ticks(105);
    check_val("pre_rst_fight", int'(state), 2);
    rst_v = 1'b1; cycle(1'b0); rst_v = 1'b0;
    check_val("rst_idle", int'(state), 0);
    check_val("rst_w2", int'(wins_2), 0);
    // Randomized play
    for (int k = 0; k < 4000; k++) begin
      h1_set = ($urandom_range(0, 39) == 0) ? 0 : $urandom_range(1, 511);
      h2_set = ($urandom_range(0, 39) == 0) ? 0 : $urandom_range(1, 511);
      if ($urandom_range(0, 29) == 0) btn = ~btn;
      if ($urandom_range(0, 1999) == 0) begin
        rst_v = 1'b1; cycle(1'b0); rst_v = 1'b0;
      end
      run_ticks(1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/match_round_controller.md
# match_round_controller

Game-flow state machine sitting directly downstream of the health-management stage. It consumes both players' health values and decides when a round starts, when it ends, and who won each round. It tracks best-of-N wins and holds the physics, health and movement stages in reset between rounds. It also gates player input through `fight_enable` and exports round timer, countdown and winner values for the status bar and LEDs.

## Interface
- `TICKS_PER_SEC`, 20: game ticks per displayed second.
- `ROUND_SECONDS`, 99: round time limit in seconds (1–127).
- `COUNTDOWN_SECONDS`, 3: pre-fight countdown length (1–3).
- `RESULT_SECONDS`, 2: hold time in ROUND_END.
- `ROUNDS_TO_WIN`, 2: round wins that end the match (1–3).

Ports:
- `clk` in 1: system clock (100 MHz); the only clock.
- `reset` in 1: synchronous, active-high.
- `tick` in 1: game-tick enable, a one-`clk` pulse at 20 Hz.
- `start` in 1: start button, level, already debounced.
- `health_1` in 9: player 1 health, unsigned.
- `health_2` in 9: player 2 health, unsigned.
- `state` out 3: 0 IDLE, 1 COUNTDOWN, 2 FIGHT, 3 ROUND_END, 4 MATCH_END.
- `round_reset` out 1: high in IDLE and COUNTDOWN; drives the reset of physics and health stages.
- `fight_enable` out 1: high only in FIGHT.
- `countdown` out 2: seconds remaining in COUNTDOWN, 0 elsewhere.
- `timer_s` out 7: round seconds remaining.
- `round_winner` out 2: last round result. 0 none, 1 P1, 2 P2, 3 draw.
- `wins_1` out 2: rounds won by player 1 this match.
- `wins_2` out 2: rounds won by player 2 this match.
- `match_winner` out 2: 0 none, 1 P1, 2 P2; valid in MATCH_END.

## Operation
**Start detection**
- `start` is registered every `clk`.
- `start_edge` = `start` & ~`start_q`.
- Only rising edges act.

**Counters**
- `sub_cnt` counts ticks 0..TICKS_PER_SEC-1.
- `sec_cnt` counts down seconds.
- Both clear on every state entry.

**State transitions**
- **IDLE**
  - On `start_edge`: go to COUNTDOWN.
  - On that transition, clear `wins_1`, `wins_2`, `round_winner` and `match_winner`.
- **COUNTDOWN**
  - `sec_cnt` loads COUNTDOWN_SECONDS; `countdown` = `sec_cnt`.
  - `timer_s` loads ROUND_SECONDS.
  - On each tick where `sub_cnt` wraps, decrement `sec_cnt`.
  - When it wraps from 1, go to FIGHT.
- **FIGHT**
  - Checks are made only on `tick` cycles, in the order below.
  - (a) `health_1`==0 and `health_2`==0: result = draw.
  - (b) `health_1`==0: result = P2.
  - (c) `health_2`==0: result = P1.
  - (d) `timer_s`==0: higher health wins; equal health is a draw.
  - A result moves the FSM to ROUND_END.
  - Otherwise, when `sub_cnt` wraps, `timer_s` decrements. `timer_s` saturates at 0.
- **ROUND_END**
  - On the entry cycle, `round_winner` = result and the winner's count increments. A draw increments neither count.
  - Hold for RESULT_SECONDS seconds of ticks.
  - Then go to MATCH_END if `wins_1` or `wins_2` == ROUNDS_TO_WIN; `match_winner` is set to that player.
  - Otherwise go back to COUNTDOWN.
- **MATCH_END**
  - All outputs are held.
  - On `start_edge`: go to IDLE.

**Other rules**
- `start_edge` is ignored in COUNTDOWN, FIGHT and ROUND_END.
- Win counters saturate at 3.

## Timing
**Reset values** (while `reset` is high):
- `state` = IDLE
- `round_reset` = 1, `fight_enable` = 0
- `countdown` = 0, `timer_s` = ROUND_SECONDS
- `round_winner` = 0, `wins_1` = 0, `wins_2` = 0, `match_winner` = 0
- `start_q` = 1, so a button held through reset produces no edge.

**Reset mid-operation**
- Reset in any state returns to IDLE on the next `clk`.
- The round in progress is abandoned and no win is recorded.

**Latency**
- All outputs are registered.
- State changes appear 1 `clk` after the qualifying `tick` or `start_edge`.
- `round_reset` falls in the same cycle that `state` becomes FIGHT.

**Durations**
- COUNTDOWN lasts exactly COUNTDOWN_SECONDS×TICKS_PER_SEC ticks.
- ROUND_END lasts exactly RESULT_SECONDS×TICKS_PER_SEC ticks.
- A full-length round runs ROUND_SECONDS×TICKS_PER_SEC ticks.
- The timeout decision is then taken on the next tick, with `timer_s`==0.

**Other timing rules**
- Health inputs are sampled only on `tick` cycles. A zero that lasts less than one tick is not seen.
- `tick` and `start_edge` in the same cycle in IDLE: the start edge wins. Counters begin on the following tick.

## Test plan
- Reset with `start`=1, hold 5 ticks: the FSM stays in IDLE, `round_reset`=1, all counts are 0. Release `start` and press it: COUNTDOWN with `countdown`=3.
- Press start, run 60 ticks: `countdown` reads 3→2→1. After the 60th tick `state`=FIGHT, `fight_enable`=1, `round_reset`=0, `timer_s`=99.
- In FIGHT set `health_2`=0 and `health_1`=50: ROUND_END with `round_winner`=1 and `wins_1`=1.
  - After 40 ticks the FSM returns to COUNTDOWN.
  - A second KO gives MATCH_END with `match_winner`=1.
- Timeout with `health_1`=120 and `health_2`=120: after 1980 fight ticks, plus one more tick, `round_winner`=3 and both win counts stay 0. Repeat with `health_1`=121: P1 wins.
- Both health values 0 on the same tick: draw, no increment.
- Assert `reset` during FIGHT with `wins_2`=1: next `clk` gives IDLE with `wins_2`=0.
- In MATCH_END: a `start` edge gives IDLE. A `start` edge during FIGHT is ignored, and `state` is unchanged.
